decode_stage: RTL and testbench

Parametrised RV32 decode stage with an internal register file, full immediate generation and a valid/ready output register. It sits between fetch and execute. It accepts one instruction per cycle and registers all decoded fields and operand data toward execute. It takes writes from writeback on an independent port.

---
 rtl/decode_stage.sv | 205 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32 decode stage: register file, immediate generation and a valid/ready output register.
// Define DECODE_FORWARD_EN to forward same-cycle writebacks into captured and stalled operands.
module decode_stage #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instruction_i,
  input  logic                 write_enable_i,
  input  logic [4:0]           write_addr_i,
  input  logic [WORD_SIZE-1:0] write_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WORD_SIZE-1:0] data_source1_o,
  output logic [WORD_SIZE-1:0] data_source2_o,
  output logic [WORD_SIZE-1:0] imm_decoded_o,
  output logic [6:0]           opcode_decoded_o,
  output logic [4:0]           reg_dest_decoded_o,
  output logic [2:0]           funct3_decoded_o,
  output logic [6:0]           funct7_decoded_o,
  output logic                 write_enable_decoded_o,
  output logic                 illegal_decoded_o
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef struct packed {
    logic [WORD_SIZE-1:0] src1;
    logic [WORD_SIZE-1:0] src2;
    logic [WORD_SIZE-1:0] imm;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 wr_en;
    logic                 illegal;
  } dec_t;

  logic [WORD_SIZE-1:0] rf_q [NUM_REGS];
  dec_t                 out_q, out_d, dec;
  logic                 out_valid_q, out_valid_d;
  logic [4:0]           rs1, rs2, rd;
  logic                 accept, wb_take;
  logic [WORD_SIZE-1:0] rs1_val, rs2_val;
  logic                 use_rs1, use_rs2, use_rd, writes, known;
  logic [31:0]          imm32;

  function automatic logic in_range(input logic [4:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  assign rs1        = instruction_i[19:15];
  assign rs2        = instruction_i[24:20];
  assign rd         = instruction_i[11:7];
  assign wb_take    = write_enable_i && (write_addr_i != 5'd0) && in_range(write_addr_i);
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && in_range(rs1)) rs1_val = rf_q[rs1[IdxW-1:0]];
    if (rs2 != 5'd0 && in_range(rs2)) rs2_val = rf_q[rs2[IdxW-1:0]];
`ifdef DECODE_FORWARD_EN
    if (wb_take && write_addr_i == rs1) rs1_val = write_data_i;
    if (wb_take && write_addr_i == rs2) rs2_val = write_data_i;
`endif
  end

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    writes  = 1'b0;
    known   = 1'b1;
    imm32   = '0;
    case (instruction_i[6:0])
      OpR: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        writes  = 1'b1;
      end
      OpImm, OpLoad, OpJalr: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        writes  = 1'b1;
        imm32   = {{20{instruction_i[31]}}, instruction_i[31:20]};
      end
      OpStore: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      end
      OpBranch: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
                   instruction_i[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        use_rd = 1'b1;
        writes = 1'b1;
        imm32  = {instruction_i[31:12], 12'h000};
      end
      OpJal: begin
        use_rd = 1'b1;
        writes = 1'b1;
        imm32  = {{12{instruction_i[31]}}, instruction_i[19:12], instruction_i[20],
                  instruction_i[30:21], 1'b0};
      end
      default: known = 1'b0;
    endcase

    dec.src1    = rs1_val;
    dec.src2    = rs2_val;
    dec.opcode  = instruction_i[6:0];
    dec.rd      = rd;
    dec.funct3  = instruction_i[14:12];
    dec.funct7  = instruction_i[31:25];
    dec.illegal = !known || (use_rs1 && !in_range(rs1)) || (use_rs2 && !in_range(rs2))
                  || (use_rd && !in_range(rd));
    dec.imm     = dec.illegal ? '0 : WORD_SIZE'($signed(imm32));
    dec.wr_en   = writes && (rd != 5'd0) && !dec.illegal;
  end

`ifdef DECODE_FORWARD_EN
  logic [4:0] rs1_q, rs2_q;
  logic       stall;

  assign stall = out_valid_q && !out_ready_i;

  // Held source indices let a stalled output pick up a late writeback.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (accept && !flush_i) begin
      rs1_q <= rs1;
      rs2_q <= rs2;
    end
  end
`endif

  always_comb begin
    out_d = out_q;
    if (accept && !flush_i) begin
      out_d = dec;
    end
`ifdef DECODE_FORWARD_EN
    else if (stall && !flush_i && wb_take) begin
      if (write_addr_i == rs1_q) out_d.src1 = write_data_i;
      if (write_addr_i == rs2_q) out_d.src2 = write_data_i;
    end
`endif
    if (flush_i)          out_valid_d = 1'b0;
    else if (accept)      out_valid_d = 1'b1;
    else if (out_ready_i) out_valid_d = 1'b0;
    else                  out_valid_d = out_valid_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_take) begin
      rf_q[write_addr_i[IdxW-1:0]] <= write_data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid_o            = out_valid_q;
  assign data_source1_o         = out_q.src1;
  assign data_source2_o         = out_q.src2;
  assign imm_decoded_o          = out_q.imm;
  assign opcode_decoded_o       = out_q.opcode;
  assign reg_dest_decoded_o     = out_q.rd;
  assign funct3_decoded_o       = out_q.funct3;
  assign funct7_decoded_o       = out_q.funct7;
  assign write_enable_decoded_o = out_q.wr_en;
  assign illegal_decoded_o      = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage built as RV32E (16 registers); follows DECODE_FORWARD_EN.
module tb_decode_stage;

  localparam int unsigned NR = 16;

  typedef struct packed {
    logic [31:0] ds1;
    logic [31:0] ds2;
    logic [31:0] imm;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        we;
    logic        ill;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, write_enable, out_ready;
  logic [31:0] instruction, write_data;
  logic [4:0]  write_addr;
  logic        in_ready, out_valid, wed, ill;
  logic [31:0] ds1, ds2, imm;
  logic [6:0]  opc, f7;
  logic [4:0]  rd;
  logic [2:0]  f3;

  logic [31:0] m_rf [32];
  logic        m_valid;
  exp_t        m_hold;
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clock = ~clock;

  decode_stage #(.WORD_SIZE(32), .NUM_REGS(NR)) dut (
    .clock_i                (clock),
    .reset_i                (reset),
    .flush_i                (flush),
    .in_valid_i             (in_valid),
    .in_ready_o             (in_ready),
    .instruction_i          (instruction),
    .write_enable_i         (write_enable),
    .write_addr_i           (write_addr),
    .write_data_i           (write_data),
    .out_valid_o            (out_valid),
    .out_ready_i            (out_ready),
    .data_source1_o         (ds1),
    .data_source2_o         (ds2),
    .imm_decoded_o          (imm),
    .opcode_decoded_o       (opc),
    .reg_dest_decoded_o     (rd),
    .funct3_decoded_o       (f3),
    .funct7_decoded_o       (f7),
    .write_enable_decoded_o (wed),
    .illegal_decoded_o      (ill)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    logic [31:0] v;
    v = (r == 5'd0 || 32'(r) >= NR) ? 32'h0 : m_rf[r];
`ifdef DECODE_FORWARD_EN
    if (write_enable && write_addr == r && r != 5'd0 && 32'(r) < NR) v = write_data;
`endif
    return v;
  endfunction

  function automatic exp_t model_decode(input logic [31:0] ins);
    exp_t               e;
    byte                fmt;
    logic signed [31:0] si;
    logic [31:0]        iv;
    logic               u1, u2, ud, bad;
    e     = '0;
    e.opc = ins[6:0];
    e.rd  = ins[11:7];
    e.f3  = ins[14:12];
    e.f7  = ins[31:25];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.ds1 = m_read(e.rs1);
    e.ds2 = m_read(e.rs2);
    case (ins[6:0])
      7'h33:               fmt = "R";
      7'h13, 7'h03, 7'h67: fmt = "I";
      7'h23:               fmt = "S";
      7'h63:               fmt = "B";
      7'h37, 7'h17:        fmt = "U";
      7'h6F:               fmt = "J";
      default:             fmt = "X";
    endcase
    si = ins;
    si = si >>> 20;
    iv = 32'h0;
    case (fmt)
      "I":     iv = si;
      "S":     iv = {si[31:5], ins[11:7]};
      "B":     iv = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      "U":     iv = {ins[31:12], 12'h000};
      "J":     iv = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: iv = 32'h0;
    endcase
    u1    = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B");
    u2    = (fmt == "R" || fmt == "S" || fmt == "B");
    ud    = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J");
    bad   = (fmt == "X") || (u1 && 32'(e.rs1) >= NR) || (u2 && 32'(e.rs2) >= NR)
            || (ud && 32'(e.rd) >= NR);
    e.ill = bad;
    e.imm = bad ? 32'h0 : iv;
    e.we  = !bad && ud && (e.rd != 5'd0);
    return e;
  endfunction

  // One clock: predict, step the model, then compare DUT outputs against the scoreboard.
  task automatic cycle();
    logic acc, wr, stall;
    #1;
    if (!reset) check("in_ready", {31'b0, in_ready}, {31'b0, !m_valid || out_ready});
    acc   = !reset && in_valid && (!m_valid || out_ready);
    stall = m_valid && !out_ready;
    wr    = write_enable && write_addr != 5'd0 && 32'(write_addr) < NR;
    if (acc && !flush) sb.push_back(model_decode(instruction));
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_valid = 1'b0;
      m_hold  = '0;
      sb.delete();
    end else begin
`ifdef DECODE_FORWARD_EN
      if (stall && wr && !flush) begin
        if (write_addr == m_hold.rs1) m_hold.ds1 = write_data;
        if (write_addr == m_hold.rs2) m_hold.ds2 = write_data;
      end
`endif
      if (wr) m_rf[write_addr] = write_data;
      m_valid = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_valid;
    end
    @(posedge clock);
    #1;
    if (acc && !flush && !reset) m_hold = sb.pop_front();
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("ds1", ds1, m_hold.ds1);
    check("ds2", ds2, m_hold.ds2);
    check("imm", imm, m_hold.imm);
    check("opcode", {25'b0, opc}, {25'b0, m_hold.opc});
    check("rd", {27'b0, rd}, {27'b0, m_hold.rd});
    check("funct3", {29'b0, f3}, {29'b0, m_hold.f3});
    check("funct7", {25'b0, f7}, {25'b0, m_hold.f7});
    check("we_dec", {31'b0, wed}, {31'b0, m_hold.we});
    check("illegal", {31'b0, ill}, {31'b0, m_hold.ill});
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid    = 1'b1;
    instruction = ins;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    write_enable = en;
    write_addr   = a;
    write_data   = d;
  endtask

  logic [31:0] prog [12];

  initial begin
    prog = '{32'h002081B3, 32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h12345037,
             32'hFFDFF0EF, 32'h00001117, 32'hFFC0A183, 32'h000080E7, 32'h001A0093,
             32'h002088B3, 32'h0000007F};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instruction = '0; out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    cycle();
    cycle();
    reset     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    out_ready = 1'b1;
    cycle();

    wb(1'b1, 5'd1, 32'd5);       cycle();
    wb(1'b1, 5'd2, 32'd7);       cycle();
    wb(1'b1, 5'd0, 32'hDEAD);    cycle();
    wb(1'b0, 5'd0, 32'h0);

    issue(32'h002081B3); cycle();
    check("add_ds1", ds1, 32'd5);
    check("add_ds2", ds2, 32'd7);
    check("add_rd", {27'b0, rd}, 32'd3);
    check("add_we", {31'b0, wed}, 32'd1);
    check("add_imm", imm, 32'd0);
    check("add_ill", {31'b0, ill}, 32'd0);

    issue(32'hFFF00093); cycle();
    check("addi_imm", imm, 32'hFFFF_FFFF);
    check("addi_x0", ds1, 32'd0);
    check("addi_we", {31'b0, wed}, 32'd1);

    // Stall for three cycles with a writeback to x1 in the middle.
    in_valid = 1'b0; cycle();
    out_ready = 1'b0;
    issue(32'h002081B3); cycle();
    in_valid = 1'b0;
    cycle();
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    wb(1'b1, 5'd1, 32'd9); cycle();
    wb(1'b0, 5'd0, 32'h0); cycle();
`ifdef DECODE_FORWARD_EN
    check("stall_ds1", ds1, 32'd9);
`else
    check("stall_ds1", ds1, 32'd5);
`endif
    check("stall_rd", {27'b0, rd}, 32'd3);
    out_ready = 1'b1; cycle();

    wb(1'b1, 5'd2, 32'h1234);
    issue(32'h002081B3); cycle();
`ifdef DECODE_FORWARD_EN
    check("fwd_ds2", ds2, 32'h1234);
`else
    check("fwd_ds2", ds2, 32'd7);
`endif
    wb(1'b0, 5'd0, 32'h0);

    issue(32'h002088B3); cycle();
    check("x17_ill", {31'b0, ill}, 32'd1);
    check("x17_we", {31'b0, wed}, 32'd0);
    issue(32'h0000007F); cycle();
    check("op7f_ill", {31'b0, ill}, 32'd1);

    // Back-to-back through every format.
    for (int i = 0; i < 12; i++) begin
      issue(prog[i]);
      cycle();
    end

    // Randomised traffic with backpressure, writebacks and occasional flush.
    for (int i = 0; i < 60; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      instruction = ($urandom_range(0, 1) == 0) ? prog[$urandom_range(0, 11)] : $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      wb(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
      cycle();
    end
    flush = 1'b0;
    wb(1'b0, 5'd0, 32'h0);

    out_ready = 1'b1; in_valid = 1'b0; cycle();
    out_ready = 1'b0;
    issue(32'h002081B3); cycle();
    in_valid = 1'b0;
    flush    = 1'b1; cycle();
    flush    = 1'b0;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_rd", {27'b0, rd}, 32'd3);

    out_ready = 1'b1;
    flush     = 1'b1;
    issue(32'h0020A423); cycle();
    flush = 1'b0;
    check("flush_acc_valid", {31'b0, out_valid}, 32'd0);

    issue(32'h002081B3); cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1; cycle();
    reset     = 1'b0;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ds1", ds1, 32'd0);
    check("rst_rd", {27'b0, rd}, 32'd0);

    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      issue((32'(i) << 20) | (32'(i) << 15) | 32'h33);
      cycle();
      check("rf_clear", ds1, 32'd0);
    end
    in_valid = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
